// File: rtl/mem_port_arbiter.sv
// Round-robin front end sharing one single-port memory among N_PORTS requesters.
// Optional build macro MEM_ARB_LOCK_EN adds a per-port lock input for atomic sequences.
module mem_port_arbiter #(
    parameter int unsigned N_PORTS      = 3,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [N_PORTS-1:0]               req,
    input  logic [N_PORTS-1:0]               we,
    input  logic [N_PORTS*ADDR_WIDTH-1:0]    addr,
    input  logic [N_PORTS*DATA_WIDTH-1:0]    wdata,
`ifdef MEM_ARB_LOCK_EN
    input  logic [N_PORTS-1:0]               lock,
`endif
    output logic [N_PORTS-1:0]               gnt,
    output logic [N_PORTS-1:0]               rvalid,
    output logic [DATA_WIDTH-1:0]            rdata,
    input  logic [DATA_WIDTH-1:0]            memory_read_data,
    output logic                             memory_write_enable,
    output logic [ADDR_WIDTH-1:0]            memory_address,
    output logic [DATA_WIDTH-1:0]            memory_write_data
);

    localparam int unsigned IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      sel_idx;
    logic [IDX_W-1:0]      cand;
    logic                  sel_any;
    logic                  hold_ptr;

    logic [ADDR_WIDTH-1:0] addr_arr  [N_PORTS];
    logic [DATA_WIDTH-1:0] wdata_arr [N_PORTS];

    logic                  issue_valid_q;
    logic [IDX_W-1:0]      issue_port_q;
    logic [READ_LATENCY-1:0] tag_valid_q;
    logic [IDX_W-1:0]      tag_port_q [READ_LATENCY];

`ifdef MEM_ARB_LOCK_EN
    logic                  lock_active_q, lock_active_d;
    logic [IDX_W-1:0]      lock_port_q, lock_port_d;
`endif

    always_comb begin
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            addr_arr[i]  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_arr[i] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Scan upward from the pointer, wrapping, and take the first requester.
    always_comb begin
        sel_any  = 1'b0;
        sel_idx  = '0;
        cand     = '0;
        hold_ptr = 1'b0;
        for (int unsigned k = 0; k < N_PORTS; k++) begin
            cand = IDX_W'((32'(ptr_q) + k) % N_PORTS);
            if (!sel_any && req[cand]) begin
                sel_any = 1'b1;
                sel_idx = cand;
            end
        end
`ifdef MEM_ARB_LOCK_EN
        // A held lock overrides round-robin and freezes the pointer.
        if (lock_active_q && req[lock_port_q] && lock[lock_port_q]) begin
            sel_any  = 1'b1;
            sel_idx  = lock_port_q;
            hold_ptr = 1'b1;
        end
        lock_active_d = sel_any && lock[sel_idx];
        lock_port_d   = sel_idx;
`endif
    end

    always_comb begin
        ptr_d = ptr_q;
        if (sel_any && !hold_ptr) begin
            ptr_d = (sel_idx == IDX_W'(N_PORTS - 1)) ? '0 : sel_idx + 1'b1;
        end
    end

    always_comb begin
        gnt = '0;
        if (sel_any && reset) begin
            gnt[sel_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q               <= '0;
            memory_write_enable <= 1'b0;
            memory_address      <= '0;
            memory_write_data   <= '0;
            issue_valid_q       <= 1'b0;
            issue_port_q        <= '0;
        end else begin
            ptr_q               <= ptr_d;
            memory_write_enable <= sel_any && we[sel_idx];
            if (sel_any) begin
                memory_address    <= addr_arr[sel_idx];
                memory_write_data <= wdata_arr[sel_idx];
            end
            issue_valid_q <= sel_any && !we[sel_idx];
            issue_port_q  <= sel_idx;
        end
    end

`ifdef MEM_ARB_LOCK_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lock_active_q <= 1'b0;
            lock_port_q   <= '0;
        end else begin
            lock_active_q <= lock_active_d;
            lock_port_q   <= lock_port_d;
        end
    end
`endif

    // Read tags trail the memory address so the return lines up with memory_read_data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_valid_q <= '0;
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                tag_port_q[i] <= '0;
            end
        end else begin
            tag_valid_q[0] <= issue_valid_q;
            tag_port_q[0]  <= issue_port_q;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_port_q[i]  <= tag_port_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            rvalid <= '0;
            if (tag_valid_q[READ_LATENCY-1]) begin
                rvalid[tag_port_q[READ_LATENCY-1]] <= 1'b1;
                rdata                              <= memory_read_data;
            end
        end
    end

endmodule
